nios2_dpram_avalon: RTL
=======================

# nios2_dpram_avalon

Parametrised true dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) on one clock, byte enables, pipelined reads with `readdatavalid`, and a hardware clear sweep after reset. It is the next-generation on-chip buffer for the Nios II subsystem, shared between the CPU data master and a second master such as a DMA or peripheral bridge.

## Interface
- `DATA_W`, 16: word width in bits; must be a multiple of 8. `BE_W = DATA_W/8`.
- `ADDR_W`, 7: word address width; `DEPTH = 2**ADDR_W`.
- `INIT_VALUE`, 0: word written to every location by the clear sweep.
- `clk` in 1: single clock for both ports and the memory.
- `reset_n` in 1: asynchronous, active-low reset.
- `s1_address` in ADDR_W: port 1 word address.
- `s1_byteenable` in BE_W: port 1 byte lanes.
- `s1_chipselect`, `s1_read`, `s1_write` in 1 each: port 1 command.
- `s1_writedata` in DATA_W: port 1 write data.
- `s1_readdata` out DATA_W: port 1 read data.
- `s1_readdatavalid` out 1: `s1_readdata` is valid this cycle.
- `s1_waitrequest` out 1: port 1 stall.
- `s2_*`: identical set for port 2.
- `init_done` out 1: clear sweep complete.

## Operation
- States are CLEAR and READY. Reset forces CLEAR with `clr_cnt = 0`.
- CLEAR writes `INIT_VALUE` to `mem[clr_cnt]` each cycle, then increments. After the cycle that writes `DEPTH-1`, the block moves to READY. Both `waitrequest` outputs are 1 in CLEAR and 0 in READY.
- A command is accepted when `chipselect & (read | write) & ~waitrequest`.
- On a write, only the byte lanes with `byteenable[i]` set are updated. A write with `byteenable = 0` is accepted and changes nothing.
- A read returns the full word regardless of `byteenable`.
- If `read` and `write` are asserted together, the access is treated as a write only and produces no `readdatavalid`.
- Both ports write the same address in the same cycle: for each byte lane enabled on both ports, s1 wins. Lanes enabled on only one port take that port's data.
- One port reads an address while the other port writes it in the same cycle: the read returns the old data (read-before-write).
- `readdata` holds its last value until the next valid read. Reads are never refused in READY, so there is no backpressure.
- Asserting `reset_n` low at any time aborts in-flight reads: `readdatavalid` goes to 0 immediately and is not reissued after reset. Memory is not reset directly; the sweep restarts from address 0 when `reset_n` rises.

## Timing
- Reset values: `s*_readdata = 0`, `s*_readdatavalid = 0`, `s*_waitrequest = 1`, `init_done = 0`.
- Clear sweep takes exactly DEPTH cycles from the first rising `clk` edge with `reset_n = 1`.
  - `init_done` and `waitrequest = 0` appear at cycle DEPTH, i.e. 128 for the defaults.
- Read latency from the acceptance edge to `readdatavalid = 1` is L: L = 1 by default, L = 2 with the configuration macro.
- One read can be accepted per port per cycle; back-to-back reads produce back-to-back valids in order.
- A write is visible to a read accepted on either port in the next cycle.

## Configuration
- `NIOS2_DPRAM_OUTREG_EN` defined: an extra register stage is placed on `readdata` and `readdatavalid`. L = 2 on both ports, with better Fmax. Reset also clears this stage.
- Undefined: L = 1 and `readdata` is driven straight from the memory read register.
- The macro affects only latency; all ordering and collision rules are unchanged.

## Test plan
- Clear sweep: release `reset_n` with defaults. `waitrequest` stays high for 128 cycles, `init_done` rises at cycle 128, and reads of addresses 0, 64 and 127 return 0x0000.
- Write then read across ports: s1 writes 0xA5C3 to address 5, then s2 reads address 5. `s2_readdata = 0xA5C3` with `readdatavalid` exactly L cycles after acceptance.
- Partial write: s1 writes 0x1234 with `byteenable = 2'b01` to address 5 (holding 0xA5C3). The following read returns 0xA534.
- Write collision: in the same cycle, s1 writes 0x1111 with `be = 01` and s2 writes 0x2222 with `be = 11`, both to address 9. A read returns 0x2211.
- Mixed read-during-write: address 3 holds 0x0F0F; s1 writes 0xF0F0 while s2 reads address 3. The read returns 0x0F0F and the next read returns 0xF0F0.
- Reset mid-traffic: pulse `reset_n` low with reads in flight on both ports.
  - `readdatavalid` drops at once and `waitrequest` goes high.
  - The sweep reruns for 128 cycles, after which address 5 reads 0x0000.

Source files
------------

// File: rtl/nios2_dpram_avalon.sv
// nios2_dpram_avalon: true dual-port on-chip RAM with two Avalon-MM slaves
// (s1, s2) on one clock. The block has byte enables, pipelined reads with
// readdatavalid, and a hardware clear sweep that runs after reset.
// Optional macro NIOS2_DPRAM_OUTREG_EN adds an output register stage, which
// raises read latency from 1 to 2 cycles.
module nios2_dpram_avalon #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 7,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    s1_address,
    input  logic [DATA_W/8-1:0]  s1_byteenable,
    input  logic                 s1_chipselect,
    input  logic                 s1_read,
    input  logic                 s1_write,
    input  logic [DATA_W-1:0]    s1_writedata,
    output logic [DATA_W-1:0]    s1_readdata,
    output logic                 s1_readdatavalid,
    output logic                 s1_waitrequest,
    input  logic [ADDR_W-1:0]    s2_address,
    input  logic [DATA_W/8-1:0]  s2_byteenable,
    input  logic                 s2_chipselect,
    input  logic                 s2_read,
    input  logic                 s2_write,
    input  logic [DATA_W-1:0]    s2_writedata,
    output logic [DATA_W-1:0]    s2_readdata,
    output logic                 s2_readdatavalid,
    output logic                 s2_waitrequest,
    output logic                 init_done
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                r_waitrequest;
    logic                r_init_done;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   r_s1_rdata;
    logic                r_s1_rvalid;
    logic [DATA_W-1:0]   r_s2_rdata;
    logic                r_s2_rvalid;

    // A write that also has read set is a write only, so it never produces readdatavalid.
    logic w_s1_wr, w_s1_rd, w_s2_wr, w_s2_rd;
    assign w_s1_wr = s1_chipselect & s1_write & ~r_waitrequest;
    assign w_s1_rd = s1_chipselect & s1_read & ~s1_write & ~r_waitrequest;
    assign w_s2_wr = s2_chipselect & s2_write & ~r_waitrequest;
    assign w_s2_rd = s2_chipselect & s2_read & ~s2_write & ~r_waitrequest;

    // Clear-sweep FSM. It holds waitrequest high until every word has been initialised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_CLEAR;
            r_clr_cnt     <= '0;
            r_waitrequest <= 1'b1;
            r_init_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    if (r_clr_cnt == '1) begin
                        r_state       <= ST_READY;
                        r_waitrequest <= 1'b0;
                        r_init_done   <= 1'b1;
                    end
                end
                default: begin
                    r_waitrequest <= 1'b0;
                    r_init_done   <= 1'b1;
                end
            endcase
        end
    end

    // Memory array writes. The sweep writes one word per cycle. In READY, the s2 lanes are
    // written first and the s1 lanes second, so s1 wins on any lane that both ports enable.
    // NOTE: the array has no reset; clearing it is the sweep's job, which keeps it mappable to block RAM.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            mem[r_clr_cnt] <= INIT_VALUE;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (w_s2_wr && s2_byteenable[i])
                    mem[s2_address][i*8 +: 8] <= s2_writedata[i*8 +: 8];
            end
            for (int i = 0; i < BE_W; i++) begin
                if (w_s1_wr && s1_byteenable[i])
                    mem[s1_address][i*8 +: 8] <= s1_writedata[i*8 +: 8];
            end
        end
    end

    // Read registers sample the array before this edge's writes land, which gives read-before-write.
    // NOTE: non-blocking assignment is what makes the read see the old word on a same-cycle collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_rdata  <= '0;
            r_s1_rvalid <= 1'b0;
            r_s2_rdata  <= '0;
            r_s2_rvalid <= 1'b0;
        end else begin
            r_s1_rvalid <= w_s1_rd;
            r_s2_rvalid <= w_s2_rd;
            if (w_s1_rd) r_s1_rdata <= mem[s1_address];
            if (w_s2_rd) r_s2_rdata <= mem[s2_address];
        end
    end

`ifdef NIOS2_DPRAM_OUTREG_EN
    logic [DATA_W-1:0] r_s1_rdata_q;
    logic              r_s1_rvalid_q;
    logic [DATA_W-1:0] r_s2_rdata_q;
    logic              r_s2_rvalid_q;

    // Extra output stage. readdata here also updates only on valid reads, so it holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_rdata_q  <= '0;
            r_s1_rvalid_q <= 1'b0;
            r_s2_rdata_q  <= '0;
            r_s2_rvalid_q <= 1'b0;
        end else begin
            r_s1_rvalid_q <= r_s1_rvalid;
            r_s2_rvalid_q <= r_s2_rvalid;
            if (r_s1_rvalid) r_s1_rdata_q <= r_s1_rdata;
            if (r_s2_rvalid) r_s2_rdata_q <= r_s2_rdata;
        end
    end

    assign s1_readdata      = r_s1_rdata_q;
    assign s1_readdatavalid = r_s1_rvalid_q;
    assign s2_readdata      = r_s2_rdata_q;
    assign s2_readdatavalid = r_s2_rvalid_q;
`else
    assign s1_readdata      = r_s1_rdata;
    assign s1_readdatavalid = r_s1_rvalid;
    assign s2_readdata      = r_s2_rdata;
    assign s2_readdatavalid = r_s2_rvalid;
`endif

    assign s1_waitrequest = r_waitrequest;
    assign s2_waitrequest = r_waitrequest;
    assign init_done      = r_init_done;

endmodule
